i2c_target_regfile: RTL and testbench

- Synthesizable I2C target (responder) with an internal byte register file; it answers transfers from the iicmb master controller on one I2C bus.
- Replaces the behavioural I2C slave model when the bench needs RTL at the target end, e.g. for gate-level or emulation runs.
- Supports 7-bit addressing, multi-byte writes and reads, repeated START, and an auto-incrementing register pointer.

---
 rtl/i2c_target_regfile.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target (responder) with a 2**PTR_WIDTH byte register file and an auto-incrementing pointer.
// SCL/SDA are oversampled on clk_i; every bus decision uses the synchronized copies.
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         DATA_WIDTH = 8,
  parameter int         PTR_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  busy_o,
  output logic                  wr_valid_o,
  output logic [PTR_WIDTH-1:0]  wr_index_o,
  output logic [DATA_WIDTH-1:0] wr_data_o
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_WR_PTR   = 4'd3,
    ST_WR_DATA  = 4'd4,
    ST_WR_ACK   = 4'd5,
    ST_RD_DATA  = 4'd6,
    ST_RD_ACK   = 4'd7,
    ST_IGNORE   = 4'd8
  } state_t;

  localparam int                   REG_COUNT = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  logic scl_s1_r, scl_s2_r, scl_h_r;
  logic sda_s1_r, sda_s2_r, sda_h_r;
  logic scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t                state_r, next_state_s;
  logic [2:0]            bit_cnt_r, bit_cnt_nxt_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_nxt_s;
  logic [PTR_WIDTH-1:0]  ptr_r, ptr_nxt_s;
  logic                  phase_r, phase_nxt_s;
  logic                  rw_r, rw_nxt_s;
  logic                  sda_r, sda_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  commit_s;
  logic                  last_bit_s, addr_match_s;
  logic [DATA_WIDTH-1:0] byte_s, rd_byte_s;

  logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
  logic                  wr_valid_r;
  logic [PTR_WIDTH-1:0]  wr_index_r;
  logic [DATA_WIDTH-1:0] wr_data_r;

  // Two-flop synchronizers plus a history flop; reset to the idle-bus level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {scl_s1_r, scl_s2_r, scl_h_r} <= 3'b111;
      {sda_s1_r, sda_s2_r, sda_h_r} <= 3'b111;
    end else begin
      {scl_s1_r, scl_s2_r, scl_h_r} <= {scl_i, scl_s1_r, scl_s2_r};
      {sda_s1_r, sda_s2_r, sda_h_r} <= {sda_i, sda_s1_r, sda_s2_r};
    end
  end

  assign scl_rise_s   = scl_s2_r & ~scl_h_r;
  assign scl_fall_s   = ~scl_s2_r & scl_h_r;
  assign start_s      = scl_s2_r & scl_h_r & sda_h_r & ~sda_s2_r;
  assign stop_s       = scl_s2_r & scl_h_r & ~sda_h_r & sda_s2_r;
  assign last_bit_s   = (bit_cnt_r == 3'd7);
  assign byte_s       = {shift_r[DATA_WIDTH-2:0], sda_s2_r};
  assign addr_match_s = (shift_r[6:0] == SLAVE_ADDR);
  assign rd_byte_s    = regs_r[ptr_r];
  // A data byte commits on its 8th sampled bit, independent of START/STOP priority
  assign commit_s     = (state_r == ST_WR_DATA) && scl_rise_s && last_bit_s;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; bus conditions override bit processing
  always_comb begin
    next_state_s = state_r;
    if (start_s) begin
      next_state_s = ST_ADDR;
    end else if (stop_s) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: next_state_s = ST_IDLE;
        ST_ADDR: begin
          if (scl_rise_s && last_bit_s) begin
            next_state_s = addr_match_s ? ST_ADDR_ACK : ST_IGNORE;
          end else begin
            next_state_s = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s && phase_r) begin
            next_state_s = rw_r ? ST_RD_DATA : ST_WR_PTR;
          end else begin
            next_state_s = ST_ADDR_ACK;
          end
        end
        ST_WR_PTR, ST_WR_DATA: begin
          if (scl_rise_s && last_bit_s) begin
            next_state_s = ST_WR_ACK;
          end else begin
            next_state_s = state_r;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall_s && phase_r) begin
            next_state_s = ST_WR_DATA;
          end else begin
            next_state_s = ST_WR_ACK;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise_s && last_bit_s) begin
            next_state_s = ST_RD_ACK;
          end else begin
            next_state_s = ST_RD_DATA;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise_s && !phase_r && sda_s2_r) begin
            next_state_s = ST_IGNORE;
          end else if (scl_fall_s && phase_r) begin
            next_state_s = ST_RD_DATA;
          end else begin
            next_state_s = ST_RD_ACK;
          end
        end
        ST_IGNORE: next_state_s = ST_IGNORE;
        default:   next_state_s = ST_IDLE;
      endcase
    end
  end

  // FSM output / datapath logic: next values of counter, shifter, pointer and SDA drive.
  // phase_r marks the second half of an ACK slot (ACK driven, or master ACK seen on reads).
  always_comb begin
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    ptr_nxt_s     = ptr_r;
    phase_nxt_s   = phase_r;
    rw_nxt_s      = rw_r;
    sda_nxt_s     = sda_r;
    busy_nxt_s    = busy_r;
    if (start_s) begin
      bit_cnt_nxt_s = 3'd0;
      phase_nxt_s   = 1'b0;
      sda_nxt_s     = 1'b1;
    end else if (stop_s) begin
      bit_cnt_nxt_s = 3'd0;
      phase_nxt_s   = 1'b0;
      sda_nxt_s     = 1'b1;
      busy_nxt_s    = 1'b0;
    end else begin
      case (state_r)
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_nxt_s   = byte_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            if (last_bit_s) begin
              rw_nxt_s    = sda_s2_r;
              phase_nxt_s = 1'b0;
              busy_nxt_s  = addr_match_s;
            end else begin
              rw_nxt_s = rw_r;
            end
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_fall_s && !phase_r) begin
            sda_nxt_s   = 1'b0;
            phase_nxt_s = 1'b1;
          end else if (scl_fall_s) begin
            phase_nxt_s   = 1'b0;
            bit_cnt_nxt_s = 3'd0;
            if ((state_r == ST_ADDR_ACK) && rw_r) begin
              sda_nxt_s   = rd_byte_s[DATA_WIDTH-1];
              shift_nxt_s = {rd_byte_s[DATA_WIDTH-2:0], 1'b0};
            end else begin
              sda_nxt_s = 1'b1;
            end
          end else begin
            phase_nxt_s = phase_r;
          end
        end
        ST_WR_PTR, ST_WR_DATA: begin
          if (scl_rise_s) begin
            shift_nxt_s   = byte_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            if (last_bit_s && (state_r == ST_WR_PTR)) begin
              ptr_nxt_s = byte_s[PTR_WIDTH-1:0];
            end else begin
              ptr_nxt_s = ptr_r;
            end
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            phase_nxt_s   = 1'b0;
          end else if (scl_fall_s) begin
            sda_nxt_s   = shift_r[DATA_WIDTH-1];
            shift_nxt_s = {shift_r[DATA_WIDTH-2:0], 1'b0};
          end else begin
            sda_nxt_s = sda_r;
          end
        end
        ST_RD_ACK: begin
          if (scl_fall_s && !phase_r) begin
            sda_nxt_s = 1'b1;
          end else if (scl_fall_s) begin
            phase_nxt_s   = 1'b0;
            bit_cnt_nxt_s = 3'd0;
            sda_nxt_s     = rd_byte_s[DATA_WIDTH-1];
            shift_nxt_s   = {rd_byte_s[DATA_WIDTH-2:0], 1'b0};
          end else if (scl_rise_s && !phase_r && !sda_s2_r) begin
            phase_nxt_s = 1'b1;
            ptr_nxt_s   = ptr_r + PTR_ONE;
          end else begin
            phase_nxt_s = phase_r;
          end
        end
        ST_IGNORE: sda_nxt_s = 1'b1;
        ST_IDLE:   sda_nxt_s = 1'b1;
        default:   sda_nxt_s = 1'b1;
      endcase
    end
    if (commit_s) begin
      ptr_nxt_s = ptr_r + PTR_ONE;
    end else begin
      ptr_nxt_s = ptr_nxt_s;
    end
  end

  // Datapath and SDA/busy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= '0;
      ptr_r     <= '0;
      phase_r   <= 1'b0;
      rw_r      <= 1'b0;
      sda_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      ptr_r     <= ptr_nxt_s;
      phase_r   <= phase_nxt_s;
      rw_r      <= rw_nxt_s;
      sda_r     <= sda_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  // Register file and write-notification outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= '0;
      end
      wr_valid_r <= 1'b0;
      wr_index_r <= '0;
      wr_data_r  <= '0;
    end else begin
      wr_valid_r <= commit_s;
      if (commit_s) begin
        regs_r[ptr_r] <= byte_s;
        wr_index_r    <= ptr_r;
        wr_data_r     <= byte_s;
      end else begin
        wr_index_r <= wr_index_r;
        wr_data_r  <= wr_data_r;
      end
    end
  end

  assign sda_o      = sda_r;
  assign busy_o     = busy_r;
  assign wr_valid_o = wr_valid_r;
  assign wr_index_o = wr_index_r;
  assign wr_data_o  = wr_data_r;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: a bit-banged I2C master runs a table of transfers against i2c_target_regfile,
// followed by hand-written repeated-START and reset-during-read sequences.
module tb_i2c_target_regfile;

  localparam int Q  = 10;
  localparam int NV = 8;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       m_scl, m_sda;
  logic       sda_o, busy_o, wr_valid_o;
  logic [3:0] wr_index_o;
  logic [7:0] wr_data_o;
  logic       sda_line;

  assign sda_line = m_sda & sda_o;

  i2c_target_regfile dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .scl_i      (m_scl),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .busy_o     (busy_o),
    .wr_valid_o (wr_valid_o),
    .wr_index_o (wr_index_o),
    .wr_data_o  (wr_data_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          busy_cnt = 0;
  int          wr_n = 0;
  logic [11:0] wr_log [0:255];

  always @(negedge clk) begin
    if (busy_o) busy_cnt <= busy_cnt + 1;
    if (wr_valid_o) begin
      wr_log[wr_n[7:0]] <= {wr_index_o, wr_data_o};
      wr_n <= wr_n + 1;
    end
  end

  typedef struct packed {
    logic            rd;
    logic [6:0]      addr;
    logic [7:0]      ptr;
    logic [2:0]      n;
    logic [3:0][7:0] data;
    logic            exp_ack;
    logic [3:0][3:0] exp_idx;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mkvec(input logic rd, input logic [6:0] addr, input logic [7:0] ptr,
                                 input logic [2:0] n, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic ack,
                                 input logic [3:0] i0, input logic [3:0] i1);
    vec_t v;
    v = '0;
    v.rd = rd; v.addr = addr; v.ptr = ptr; v.n = n; v.exp_ack = ack;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
    v.exp_idx[0] = i0; v.exp_idx[1] = i1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; hold();
    m_scl = 1'b1; hold();
    m_sda = 1'b0; hold();
    m_scl = 1'b0; hold();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; hold();
    m_scl = 1'b1; hold();
    m_sda = 1'b1; hold();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; hold();
    m_scl = 1'b1; hold(); hold();
    m_scl = 1'b0; hold();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; hold();
    m_scl = 1'b1; hold();
    b = sda_line; hold();
    m_scl = 1'b0; hold();
  endtask

  // Returns the acknowledge bit as seen on the line (0 = ACK)
  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_bit);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic run_vec(input vec_t v);
    int base, bbase, nexp;
    logic a;
    logic [7:0] d;
    base  = wr_n;
    bbase = busy_cnt;
    nexp  = (!v.rd && v.exp_ack) ? int'(v.n) : 0;
    i2c_start();
    write_byte({v.addr, 1'b0}, a);
    check("addr_ack", {31'd0, ~a}, {31'd0, v.exp_ack});
    write_byte(v.ptr, a);
    check("ptr_ack", {31'd0, ~a}, {31'd0, v.exp_ack});
    if (!v.rd) begin
      for (int k = 0; k < int'(v.n); k++) begin
        write_byte(v.data[k], a);
        check("data_ack", {31'd0, ~a}, {31'd0, v.exp_ack});
      end
    end else begin
      i2c_start();
      write_byte({v.addr, 1'b1}, a);
      check("rd_addr_ack", {31'd0, ~a}, {31'd0, v.exp_ack});
      for (int k = 0; k < int'(v.n); k++) begin
        read_byte(d, (k == int'(v.n) - 1));
        check("rd_data", {24'd0, d}, {24'd0, v.data[k]});
      end
      check("rd_release", {31'd0, sda_o}, 32'd1);
    end
    i2c_stop();
    check("busy_seen", {31'd0, (busy_cnt != bbase)}, {31'd0, v.exp_ack});
    check("busy_after_stop", {31'd0, busy_o}, 32'd0);
    check("wr_count", wr_n - base, nexp);
    for (int k = 0; k < nexp; k++) begin
      check("wr_index", {28'd0, wr_log[base + k][11:8]}, {28'd0, v.exp_idx[k]});
      check("wr_data", {24'd0, wr_log[base + k][7:0]}, {24'd0, v.data[k]});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, b;
    logic [7:0] d;
    int base;

    vecs[0] = mkvec(1'b0, 7'h23, 8'h03, 3'd2, 8'hAB, 8'hCD, 8'h00, 1'b0, 4'h0, 4'h0);
    vecs[1] = mkvec(1'b0, 7'h22, 8'h03, 3'd2, 8'hAB, 8'hCD, 8'h00, 1'b1, 4'h3, 4'h4);
    vecs[2] = mkvec(1'b1, 7'h22, 8'h03, 3'd3, 8'hAB, 8'hCD, 8'h00, 1'b1, 4'h0, 4'h0);
    vecs[3] = mkvec(1'b0, 7'h22, 8'h0F, 3'd2, 8'h11, 8'h22, 8'h00, 1'b1, 4'hF, 4'h0);
    vecs[4] = mkvec(1'b1, 7'h22, 8'h0F, 3'd2, 8'h11, 8'h22, 8'h00, 1'b1, 4'h0, 4'h0);
    vecs[5] = mkvec(1'b0, 7'h22, 8'hA7, 3'd1, 8'h5A, 8'h00, 8'h00, 1'b1, 4'h7, 4'h0);
    vecs[6] = mkvec(1'b1, 7'h22, 8'h07, 3'd1, 8'h5A, 8'h00, 8'h00, 1'b1, 4'h0, 4'h0);
    vecs[7] = mkvec(1'b1, 7'h22, 8'h00, 3'd1, 8'h22, 8'h00, 8'h00, 1'b1, 4'h0, 4'h0);

    rst_i = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_sda", {31'd0, sda_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid_o}, 32'd0);
    check("rst_wr_index", {28'd0, wr_index_o}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data_o}, 32'd0);
    rst_i = 1'b0;
    hold();

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Repeated START after 4 data bits: partial byte dropped, new transfer works
    base = wr_n;
    i2c_start();
    write_byte(8'h44, a);
    check("rs_addr_ack", {31'd0, ~a}, 32'd1);
    write_byte(8'h08, a);
    check("rs_ptr_ack", {31'd0, ~a}, 32'd1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_start();
    write_byte(8'h44, a);
    check("rs_readdr_ack", {31'd0, ~a}, 32'd1);
    check("rs_no_partial_write", wr_n - base, 32'd0);
    write_byte(8'h08, a);
    write_byte(8'h77, a);
    check("rs_data_ack", {31'd0, ~a}, 32'd1);
    i2c_stop();
    check("rs_wr_count", wr_n - base, 32'd1);
    check("rs_wr_entry", {20'd0, wr_log[base]}, 32'h877);

    // Reset while the target holds SDA low during a read of 0xAB
    i2c_start();
    write_byte(8'h44, a);
    write_byte(8'h03, a);
    i2c_start();
    write_byte(8'h45, a);
    check("rr_addr_ack", {31'd0, ~a}, 32'd1);
    read_bit(b);
    check("rr_bit7", {31'd0, b}, 32'd1);
    check("rr_sda_low", {31'd0, sda_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("rr_sda_released", {31'd0, sda_o}, 32'd1);
    check("rr_busy_cleared", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    hold();
    i2c_stop();
    i2c_start();
    write_byte(8'h44, a);
    check("rr_post_addr_ack", {31'd0, ~a}, 32'd1);
    write_byte(8'h03, a);
    check("rr_post_ptr_ack", {31'd0, ~a}, 32'd1);
    i2c_start();
    write_byte(8'h45, a);
    read_byte(d, 1'b1);
    check("rr_regs_cleared", {24'd0, d}, 32'd0);
    i2c_stop();
    check("rr_final_busy", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
